// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared state type, codec register map and frame packing for codec_cfg_arbiter
package codec_cfg_pkg;

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, WAIT} state_t;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;

  localparam logic [6:0] REG_LLINE  = 7'd0;
  localparam logic [6:0] REG_RLINE  = 7'd1;
  localparam logic [6:0] REG_LHP    = 7'd2;
  localparam logic [6:0] REG_RHP    = 7'd3;
  localparam logic [6:0] REG_APATH  = 7'd4;
  localparam logic [6:0] REG_DPATH  = 7'd5;
  localparam logic [6:0] REG_PWR    = 7'd6;
  localparam logic [6:0] REG_IFACE  = 7'd7;
  localparam logic [6:0] REG_SRATE  = 7'd8;
  localparam logic [6:0] REG_ACTIVE = 7'd9;

  // I2C address byte carries the write bit (0) in its LSB.
  function automatic logic [23:0] pack_word(input logic [6:0] addr7, input logic [8:0] data9,
                                            input logic [6:0] dev7 = DEV_ADDR_DEF);
    return {dev7, 1'b0, addr7, data9};
  endfunction

endpackage

// File: rtl/codec_cfg_arbiter_rr_picker.sv
// rtl/codec_cfg_arbiter_rr_picker.sv - combinational round-robin select of the first set request at or after a pointer
module rr_picker #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_any,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_pos;

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    w_pos = '0;
    // Offsets are walked high to low so the nearest set bit after the pointer is written last.
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = W'((int'(i_ptr) + k) % N);
      if (i_req[w_pos]) o_idx = w_pos;
    end
  end

endmodule

// File: rtl/codec_cfg_arbiter.sv
// rtl/codec_cfg_arbiter.sv - round-robin sharing of the codec I2C write engine with retry, timeout and per-requester status
module codec_cfg_arbiter
  import codec_cfg_pkg::*;
#(
  parameter int         N_REQ       = 2,
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
  parameter int         MAX_RETRY   = 1,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_init_done,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [16*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]    o_grant,
  output logic [N_REQ-1:0]    o_done,
  output logic [N_REQ-1:0]    o_err,
  output logic                o_eng_start,
  output logic [23:0]         o_eng_word,
  input  logic                i_eng_done,
  input  logic                i_eng_ack_ok,
  output logic                o_busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_owner, w_owner_nxt;
  logic [PW-1:0]    w_pick_idx, w_owner_inc;
  logic [RW-1:0]    r_retry, w_retry_nxt;
  logic [TW-1:0]    r_tmo, w_tmo_nxt;
  logic [23:0]      r_word, w_word_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic [N_REQ-1:0] r_err, w_err_nxt;
  logic             r_start, w_start_nxt;
  logic             r_busy;
  logic             w_pick_any;
  logic [15:0]      w_slice;

  rr_picker #(.N(N_REQ), .W(PW)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  assign w_slice     = i_req_data[{w_pick_idx, 4'b0000} +: 16];
  assign w_owner_inc = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_retry_nxt = r_retry;
    w_tmo_nxt   = r_tmo;
    w_word_nxt  = r_word;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_start_nxt = 1'b0;
    case (r_state)
      WAIT_INIT: if (i_init_done) w_state_nxt = IDLE;
      IDLE: begin
        if (w_pick_any) begin
          w_owner_nxt             = w_pick_idx;
          w_word_nxt              = pack_word(w_slice[15:9], w_slice[8:0], DEV_ADDR);
          w_retry_nxt             = '0;
          w_grant_nxt[w_pick_idx] = 1'b1;
          w_start_nxt             = 1'b1;
          w_state_nxt             = ISSUE;
        end
      end
      ISSUE: begin
        w_tmo_nxt   = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // An engine result in the timeout cycle takes priority over the timeout.
        if (i_eng_done && i_eng_ack_ok) begin
          w_done_nxt[r_owner] = 1'b1;
          w_ptr_nxt           = w_owner_inc;
          w_state_nxt         = IDLE;
        end else if (i_eng_done && (r_retry < RW'(MAX_RETRY))) begin
          w_retry_nxt = r_retry + RW'(1);
          w_start_nxt = 1'b1;
          w_state_nxt = ISSUE;
        end else if (i_eng_done || (r_tmo == TW'(TIMEOUT_CYC))) begin
          w_err_nxt[r_owner] = 1'b1;
          w_ptr_nxt          = w_owner_inc;
          w_state_nxt        = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      default: w_state_nxt = WAIT_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= WAIT_INIT;
      r_ptr   <= '0;
      r_owner <= '0;
      r_retry <= '0;
      r_tmo   <= '0;
      r_word  <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_retry <= w_retry_nxt;
      r_tmo   <= w_tmo_nxt;
      r_word  <= w_word_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_start <= w_start_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_eng_start = r_start;
  assign o_eng_word  = r_word;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// tb/tb_codec_cfg_arbiter.sv - directed bench with a transaction-age reference model for codec_cfg_arbiter
module tb_codec_cfg_arbiter;

  localparam int N  = 2;
  localparam int T  = 1023;
  localparam int MR = 1;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_init_done = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [16*N-1:0] i_req_data = '0;
  logic            i_eng_done = 1'b0;
  logic            i_eng_ack_ok = 1'b0;
  logic [N-1:0]    o_grant, o_done, o_err;
  logic            o_eng_start, o_busy;
  logic [23:0]     o_eng_word;

  codec_cfg_arbiter #(.N_REQ(N), .DEV_ADDR(7'h1A), .MAX_RETRY(MR), .TIMEOUT_CYC(T)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_init_done  (i_init_done),
    .i_req        (i_req),
    .i_req_data   (i_req_data),
    .o_grant      (o_grant),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_eng_start  (o_eng_start),
    .o_eng_word   (o_eng_word),
    .i_eng_done   (i_eng_done),
    .i_eng_ack_ok (i_eng_ack_ok),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  function automatic int oh(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: tracks whether a write is in flight and its age since the last start pulse.
  logic [N-1:0] m_grant = '0, m_done = '0, m_err = '0;
  logic         m_start = 1'b0, m_busy = 1'b0;
  logic [23:0]  m_word = '0;
  bit           m_armed = 0, m_inflight = 0;
  int           m_owner = 0, m_ptr = 0, m_age = 0, m_nacks = 0;

  initial begin
    int j;
    logic [4:0] base;
    forever begin
      @(posedge i_clk or posedge i_rst);
      m_grant = '0; m_done = '0; m_err = '0; m_start = 1'b0;
      if (i_rst) begin
        m_word = '0; m_armed = 0; m_inflight = 0; m_ptr = 0; m_owner = 0;
        m_busy = 1'b0;
      end else begin
        if (!m_armed) begin
          m_armed = i_init_done;
        end else if (!m_inflight) begin
          for (int off = 0; off < N; off++) begin
            j = (m_ptr + off) % N;
            if (!m_inflight && i_req[j]) begin
              base = 5'(16 * j);
              m_inflight = 1; m_owner = j; m_age = 0; m_nacks = 0;
              m_word = {7'h1A, 1'b0, i_req_data[base +: 16]};
              m_grant[j] = 1'b1; m_start = 1'b1;
            end
          end
        end else begin
          m_age++;
          if (m_age >= 2 && i_eng_done && i_eng_ack_ok) begin
            m_done[m_owner] = 1'b1; m_inflight = 0; m_ptr = (m_owner + 1) % N;
          end else if (m_age >= 2 && i_eng_done && m_nacks < MR) begin
            m_nacks++; m_age = 0; m_start = 1'b1;
          end else if (m_age >= 2 && (i_eng_done || m_age == T + 2)) begin
            m_err[m_owner] = 1'b1; m_inflight = 0; m_ptr = (m_owner + 1) % N;
          end
        end
        m_busy = !(m_armed && !m_inflight);
      end
    end
  end

  initial forever begin
    @(negedge i_clk);
    checks++;
    if ({o_grant, o_done, o_err, o_eng_start, o_busy, o_eng_word} !==
        {m_grant, m_done, m_err, m_start, m_busy, m_word}) begin
      errors++;
      $display("FAIL cycle %0d outputs: got g=%b d=%b e=%b s=%b b=%b w=%h, want g=%b d=%b e=%b s=%b b=%b w=%h",
               cyc, o_grant, o_done, o_err, o_eng_start, o_busy, o_eng_word,
               m_grant, m_done, m_err, m_start, m_busy, m_word);
    end
  end

  int g_idx[$], g_cyc[$], s_cyc[$], d_idx[$], d_cyc[$], e_idx[$], e_cyc[$];
  logic [23:0] s_word[$];

  initial forever begin
    @(negedge i_clk);
    if (o_grant != 0) begin g_idx.push_back(oh(o_grant)); g_cyc.push_back(cyc); end
    if (o_eng_start) begin s_cyc.push_back(cyc); s_word.push_back(o_eng_word); end
    if (o_done != 0) begin d_idx.push_back(oh(o_done)); d_cyc.push_back(cyc); end
    if (o_err != 0) begin e_idx.push_back(oh(o_err)); e_cyc.push_back(cyc); end
  end

  task automatic clear_logs();
    g_idx.delete(); g_cyc.delete(); s_cyc.delete(); s_word.delete();
    d_idx.delete(); d_cyc.delete(); e_idx.delete(); e_cyc.delete();
  endtask

  // Engine stand-in: each start consumes one queued {delay, ack}; delay -1 means never answer.
  int rsp_dly[$];
  bit rsp_ack[$];
  int eng_cnt = -1;
  bit eng_ack = 0;
  bit stray = 0;

  initial forever begin
    @(negedge i_clk);
    i_eng_done = 1'b0; i_eng_ack_ok = 1'b0;
    if (i_rst) eng_cnt = -1;
    else if (o_eng_start && rsp_dly.size() > 0) begin
      eng_cnt = rsp_dly.pop_front(); eng_ack = rsp_ack.pop_front();
    end else if (eng_cnt > 0) eng_cnt--;
    if (eng_cnt == 0) begin i_eng_done = 1'b1; i_eng_ack_ok = eng_ack; eng_cnt = -1; end
    if (stray) begin i_eng_done = 1'b1; i_eng_ack_ok = 1'b1; stray = 0; end
  end

  task automatic push_rsp(input int d, input bit a);
    rsp_dly.push_back(d); rsp_ack.push_back(a);
  endtask

  task automatic step(input int n, input bit drop);
    repeat (n) begin
      @(negedge i_clk);
      if (drop) i_req = i_req & ~o_grant;
    end
  endtask

  int exp_seq[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    int c0, n;
    step(3, 0);
    chk("reset_outputs", {o_grant, o_done, o_err, o_eng_start, o_busy, o_eng_word}, 0);
    i_rst = 1'b0;

    // Requests held off until the table load finishes.
    clear_logs();
    i_req_data[15:0] = {7'd2, 9'h017};
    i_req = 2'b01;
    push_rsp(5, 1);
    step(50, 0);
    chk("pre_init_grants", g_idx.size(), 0);
    chk("pre_init_starts", s_cyc.size(), 0);
    i_init_done = 1'b1; c0 = cyc;
    step(12, 1);
    chk("t1_grant_count", g_idx.size(), 1);
    if (g_idx.size() > 0) begin
      chk("t1_grant_idx", g_idx[0], 0);
      chk("t1_grant_cycle", g_cyc[0], c0 + 2);
    end
    if (s_word.size() > 0) chk("t1_word", s_word[0], 24'h340417);
    chk("t1_done_count", d_idx.size(), 1);
    if (d_cyc.size() > 0 && s_cyc.size() > 0) chk("t1_done_cycle", d_cyc[0], s_cyc[0] + 6);

    // Both requesters continuously high: strict alternation.
    clear_logs();
    i_req_data = {7'd3, 9'h1FF, 7'd5, 9'h006};
    for (int i = 0; i < 8; i++) push_rsp(30, 1);
    i_req = 2'b11;
    n = 0;
    for (int i = 0; i < 700 && n < 8; i++) begin
      @(negedge i_clk);
      if (o_done != 0) n++;
    end
    i_req = 2'b00;
    step(3, 0);
    chk("t2_done_count", n, 8);
    chk("t2_grant_count", g_idx.size(), 8);
    for (int i = 0; i < 8 && i < g_idx.size() && i < d_idx.size(); i++) begin
      chk($sformatf("t2_grant_%0d", i), g_idx[i], exp_seq[i]);
      chk($sformatf("t2_done_%0d", i), d_idx[i], exp_seq[i]);
    end
    if (s_word.size() > 1) begin
      chk("t2_word_req1", s_word[0], 24'h3407FF);
      chk("t2_word_req0", s_word[1], 24'h340A06);
    end
    if (d_cyc.size() > 0 && g_cyc.size() > 1) begin
      chk("t2_done_latency", d_cyc[0] - s_cyc[0], 31);
      chk("t2_regrant_gap", g_cyc[1] - d_cyc[0], 1);
    end

    // One NACK then ACK: retried with the same word, single grant.
    clear_logs();
    i_req_data[15:0] = {7'd4, 9'h012};
    push_rsp(4, 0); push_rsp(4, 1);
    i_req = 2'b01;
    step(25, 1);
    chk("t3_starts", s_cyc.size(), 2);
    chk("t3_grants", g_idx.size(), 1);
    chk("t3_dones", d_idx.size(), 1);
    chk("t3_errs", e_idx.size(), 0);
    if (s_word.size() > 1) begin
      chk("t3_word_first", s_word[0], 24'h340812);
      chk("t3_word_retry", s_word[1], 24'h340812);
      chk("t3_retry_gap", s_cyc[1] - s_cyc[0], 5);
    end

    // Two NACKs: error for requester 1, then requester 0 is served.
    clear_logs();
    i_req_data = {7'd9, 9'h001, 7'd7, 9'h042};
    push_rsp(3, 0); push_rsp(3, 0); push_rsp(3, 1);
    i_req = 2'b11;
    step(30, 1);
    chk("t4_errs", e_idx.size(), 1);
    if (e_idx.size() > 0) chk("t4_err_idx", e_idx[0], 1);
    chk("t4_grants", g_idx.size(), 2);
    if (g_idx.size() > 1) begin
      chk("t4_grant_first", g_idx[0], 1);
      chk("t4_grant_second", g_idx[1], 0);
      if (e_cyc.size() > 0) chk("t4_regrant_gap", g_cyc[1] - e_cyc[0], 1);
    end
    chk("t4_dones", d_idx.size(), 1);
    if (d_idx.size() > 0) chk("t4_done_idx", d_idx[0], 0);
    chk("t4_starts", s_cyc.size(), 3);

    // Engine silent: timeout error, then a stray done in IDLE is ignored.
    clear_logs();
    i_req_data[31:16] = {7'd6, 9'h000};
    push_rsp(-1, 0);
    i_req = 2'b10;
    n = 0;
    while (e_cyc.size() == 0 && n < T + 40) begin step(1, 1); n++; end
    chk("t5_err_seen", e_cyc.size(), 1);
    if (e_cyc.size() > 0 && s_cyc.size() > 0) begin
      chk("t5_err_idx", e_idx[0], 1);
      chk("t5_err_cycle", e_cyc[0] - s_cyc[0], T + 2);
    end
    chk("t5_no_done", d_idx.size(), 0);
    step(2, 0);
    stray = 1;
    step(10, 0);
    chk("t5_stray_starts", s_cyc.size(), 1);
    chk("t5_stray_dones", d_idx.size(), 0);

    // Done arriving in the timeout cycle wins.
    clear_logs();
    push_rsp(T + 1, 1);
    i_req = 2'b10;
    n = 0;
    while (d_cyc.size() == 0 && e_cyc.size() == 0 && n < T + 40) begin step(1, 1); n++; end
    step(2, 0);
    chk("t5b_dones", d_idx.size(), 1);
    chk("t5b_errs", e_idx.size(), 0);
    if (d_cyc.size() > 0 && s_cyc.size() > 0) chk("t5b_done_cycle", d_cyc[0] - s_cyc[0], T + 2);

    // Reset in WAIT: outputs clear at once, then wait for the table load again.
    clear_logs();
    i_req_data[15:0] = {7'd9, 9'h001};
    push_rsp(-1, 0);
    i_req = 2'b01;
    n = 0;
    while (s_cyc.size() == 0 && n < 10) begin step(1, 0); n++; end
    step(5, 0);
    chk("t6_busy_before_rst", o_busy, 1);
    #2;
    i_rst = 1'b1; i_init_done = 1'b0;
    rsp_dly.delete(); rsp_ack.delete();
    #1;
    chk("t6_async_clear", {o_grant, o_done, o_err, o_eng_start, o_busy, o_eng_word}, 0);
    step(3, 0);
    i_rst = 1'b0;
    clear_logs();
    step(20, 1);
    chk("t6_blocked_grants", g_idx.size(), 0);
    push_rsp(2, 1);
    i_init_done = 1'b1; c0 = cyc;
    step(10, 1);
    chk("t6_grants", g_idx.size(), 1);
    if (g_cyc.size() > 0) chk("t6_grant_cycle", g_cyc[0], c0 + 2);
    chk("t6_dones", d_idx.size(), 1);

    step(2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got no completion by time %0t, want completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
